mlow_stream_monitor: RTL and testbench

Synthesizable, parametrised protocol monitor for the MLow codec datapath. It checks NUM_CH valid/ready audio channels and the byte-wide packet stream for handshake stability, stall timeouts, packet framing and quality-metric range. Violations are reported as sticky error flags with a one-cycle interrupt pulse, and saturating frame and packet counters are exposed. It sits beside `mlow_codec` in both simulation and silicon builds and replaces the testbench-only checks.

---
 rtl/mlow_mon_pkg.sv | 22 ++
 rtl/mlow_chan_monitor.sv | 90 +++++++++
 rtl/mlow_stream_monitor.sv | 175 +++++++++++++++++
 tb/tb_mlow_stream_monitor.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlow_mon_pkg.sv
// Shared definitions for the MLow stream monitor: error bit positions,
// quality threshold and packet framing states.
package mlow_mon_pkg;

  localparam int ERR_W            = 8;
  localparam int ERR_STABLE_VALID = 0;
  localparam int ERR_STABLE_DATA  = 1;
  localparam int ERR_TIMEOUT      = 2;
  localparam int ERR_PKT_SE       = 3;
  localparam int ERR_PKT_NEST     = 4;
  localparam int ERR_PKT_ORPHAN   = 5;
  localparam int ERR_PKT_LEN      = 6;
  localparam int ERR_QUALITY      = 7;

  localparam int QUALITY_MAX = 100;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } pkt_state_e;

endpackage

// File: rtl/mlow_chan_monitor.sv
// Per-channel valid/ready checker: handshake stability, stall timeout and
// a saturating count of completed frames.
module mlow_chan_monitor
  import mlow_mon_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int FRAME_LEN   = 16,
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [2:0]        err_o,
  output logic [CNT_W-1:0]  frame_count_o
);

  localparam int SC_W = $clog2(TIMEOUT_CYC + 1);
  localparam int BC_W = $clog2(FRAME_LEN);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic              stalled;
  logic              accept;
  logic              stall_q;
  logic [DATA_W-1:0] data_q;
  logic [SC_W-1:0]   scnt_q, scnt_d;
  logic [BC_W-1:0]   beat_q, beat_d;
  logic [CNT_W-1:0]  frame_q, frame_d;
  logic              wrap;

  assign stalled = valid_i & ~ready_i;
  assign accept  = valid_i & ready_i;

  // Violation detection plus next state of stall, beat and frame counters
  always_comb begin
    scnt_d  = scnt_q;
    beat_d  = beat_q;
    frame_d = frame_q;
    wrap    = 1'b0;
    err_o   = '0;
    err_o[ERR_STABLE_VALID] = stall_q & ~valid_i;
    err_o[ERR_STABLE_DATA]  = stall_q & valid_i & (data_i != data_q);
    if (stalled) begin
      // counter parks at TIMEOUT_CYC so the timeout is reported only once
      if (scnt_q != SC_W'(TIMEOUT_CYC)) scnt_d = scnt_q + SC_W'(1);
      err_o[ERR_TIMEOUT] = (scnt_q == SC_W'(TIMEOUT_CYC - 1));
    end else begin
      scnt_d = '0;
    end
    if (accept) begin
      if (beat_q == BC_W'(FRAME_LEN - 1)) begin
        beat_d = '0;
        wrap   = 1'b1;
      end else begin
        beat_d = beat_q + BC_W'(1);
      end
    end
    if (clear_i)   frame_d = '0;
    else if (wrap) frame_d = sat_inc(frame_q);
  end

  // Control state; reset clears the stall history so no check fires right after reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_q <= 1'b0;
      scnt_q  <= '0;
      beat_q  <= '0;
      frame_q <= '0;
    end else begin
      stall_q <= stalled;
      scnt_q  <= scnt_d;
      beat_q  <= beat_d;
      frame_q <= frame_d;
    end
  end

  // Previous-cycle sample, only meaningful while stall_q is set
  always_ff @(posedge clk_i) begin
    data_q <= data_i;
  end

  assign frame_count_o = frame_q;

endmodule

// File: rtl/mlow_stream_monitor.sv
// Protocol monitor for the MLow codec datapath: per-channel handshake checks,
// packet framing FSM, quality range check, sticky error flags with an
// interrupt pulse, and saturating frame/packet counters.
module mlow_stream_monitor
  import mlow_mon_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int NUM_CH      = 2,
  parameter int FRAME_LEN   = 16,
  parameter int PKT_W       = 8,
  parameter int MAX_PKT_LEN = 64,
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_CH-1:0]        ch_valid_i,
  input  logic [NUM_CH-1:0]        ch_ready_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  input  logic                     pkt_valid_i,
  input  logic                     pkt_ready_i,
  input  logic [PKT_W-1:0]         pkt_data_i,
  input  logic                     pkt_start_i,
  input  logic                     pkt_end_i,
  input  logic                     quality_valid_i,
  input  logic [7:0]               quality_metric_i,
  input  logic                     clear_i,
  output logic [ERR_W-1:0]         err_flags_o,
  output logic [NUM_CH-1:0]        err_ch_o,
  output logic                     err_irq_o,
  output logic [NUM_CH*CNT_W-1:0]  frame_count_o,
  output logic [CNT_W-1:0]         pkt_count_o
);

  localparam int LW = $clog2(MAX_PKT_LEN + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [NUM_CH-1:0][2:0] ch_err;
  logic [2:0]             ch_agg;
  logic [NUM_CH-1:0]      ch_hit;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mlow_chan_monitor #(
      .DATA_W      (DATA_W),
      .FRAME_LEN   (FRAME_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .clear_i       (clear_i),
      .valid_i       (ch_valid_i[c]),
      .ready_i       (ch_ready_i[c]),
      .data_i        (ch_data_i[c*DATA_W +: DATA_W]),
      .err_o         (ch_err[c]),
      .frame_count_o (frame_count_o[c*CNT_W +: CNT_W])
    );
  end

  // The packet payload is not inspected; only the framing markers matter
  logic pkt_data_unused;
  assign pkt_data_unused = ^pkt_data_i;

  // Merge per-channel violations into flag bits and the channel mask
  always_comb begin
    ch_agg = '0;
    ch_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_agg    = ch_agg | ch_err[c];
      ch_hit[c] = |ch_err[c];
    end
  end

  pkt_state_e      state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic            pkt_acc;
  logic            pkt_done;
  logic            ev_se, ev_nest, ev_orphan, ev_len;

  assign pkt_acc = pkt_valid_i & pkt_ready_i;

  // Packet framing FSM; only accepted beats move it
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    pkt_done  = 1'b0;
    ev_se     = 1'b0;
    ev_nest   = 1'b0;
    ev_orphan = 1'b0;
    ev_len    = 1'b0;
    if (pkt_acc) begin
      ev_se = pkt_start_i & pkt_end_i;
      case (state_q)
        IDLE: begin
          if (!pkt_start_i) begin
            ev_orphan = 1'b1;
          end else if (!pkt_end_i) begin
            state_d = OPEN;
            len_d   = LW'(1);
          end
        end
        OPEN: begin
          if (pkt_start_i) begin
            ev_nest = 1'b1;
            len_d   = LW'(1);
          end else if (pkt_end_i) begin
            state_d  = IDLE;
            pkt_done = 1'b1;
          end else if (len_q == LW'(MAX_PKT_LEN)) begin
            // this beat would be number MAX_PKT_LEN+1: abandon the packet
            ev_len  = 1'b1;
            state_d = IDLE;
          end else begin
            len_d = len_q + LW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  logic [ERR_W-1:0]  ev;
  logic [ERR_W-1:0]  flags_q, flags_d, flags_base;
  logic [NUM_CH-1:0] errch_q, errch_d;
  logic              irq_q, irq_d;
  logic [CNT_W-1:0]  pkt_q, pkt_d;

  // Sticky flags; an error arriving with clear_i survives the clear and still pulses irq
  always_comb begin
    ev                   = '0;
    ev[ERR_STABLE_VALID] = ch_agg[ERR_STABLE_VALID];
    ev[ERR_STABLE_DATA]  = ch_agg[ERR_STABLE_DATA];
    ev[ERR_TIMEOUT]      = ch_agg[ERR_TIMEOUT];
    ev[ERR_PKT_SE]       = ev_se;
    ev[ERR_PKT_NEST]     = ev_nest;
    ev[ERR_PKT_ORPHAN]   = ev_orphan;
    ev[ERR_PKT_LEN]      = ev_len;
    ev[ERR_QUALITY]      = quality_valid_i & (quality_metric_i > 8'(QUALITY_MAX));
    flags_base = clear_i ? '0 : flags_q;
    flags_d    = flags_base | ev;
    irq_d      = |(ev & ~flags_base);
    errch_d    = (clear_i ? '0 : errch_q) | ch_hit;
    if (clear_i)       pkt_d = '0;
    else if (pkt_done) pkt_d = sat_inc(pkt_q);
    else               pkt_d = pkt_q;
  end

  // Registered FSM, flags, irq and packet counter
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      flags_q <= '0;
      errch_q <= '0;
      irq_q   <= 1'b0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      flags_q <= flags_d;
      errch_q <= errch_d;
      irq_q   <= irq_d;
      pkt_q   <= pkt_d;
    end
  end

  assign err_flags_o = flags_q;
  assign err_ch_o    = errch_q;
  assign err_irq_o   = irq_q;
  assign pkt_count_o = pkt_q;

endmodule

// File: tb/tb_mlow_stream_monitor.sv
// Bench for mlow_stream_monitor: directed scenarios followed by random
// traffic, all outputs compared every cycle against a behavioural model.
module tb_mlow_stream_monitor;

  localparam int DATA_W      = 16;
  localparam int NUM_CH      = 2;
  localparam int FRAME_LEN   = 16;
  localparam int PKT_W       = 8;
  localparam int MAX_PKT_LEN = 64;
  localparam int TIMEOUT_CYC = 256;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic                     clk;
  logic                     reset_i;
  logic [NUM_CH-1:0]        ch_valid_i;
  logic [NUM_CH-1:0]        ch_ready_i;
  logic [NUM_CH*DATA_W-1:0] ch_data_i;
  logic                     pkt_valid_i;
  logic                     pkt_ready_i;
  logic [PKT_W-1:0]         pkt_data_i;
  logic                     pkt_start_i;
  logic                     pkt_end_i;
  logic                     quality_valid_i;
  logic [7:0]               quality_metric_i;
  logic                     clear_i;
  logic [7:0]               err_flags_o;
  logic [NUM_CH-1:0]        err_ch_o;
  logic                     err_irq_o;
  logic [NUM_CH*CNT_W-1:0]  frame_count_o;
  logic [CNT_W-1:0]         pkt_count_o;

  mlow_stream_monitor #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .FRAME_LEN(FRAME_LEN), .PKT_W(PKT_W),
    .MAX_PKT_LEN(MAX_PKT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .ch_valid_i(ch_valid_i), .ch_ready_i(ch_ready_i), .ch_data_i(ch_data_i),
    .pkt_valid_i(pkt_valid_i), .pkt_ready_i(pkt_ready_i), .pkt_data_i(pkt_data_i),
    .pkt_start_i(pkt_start_i), .pkt_end_i(pkt_end_i),
    .quality_valid_i(quality_valid_i), .quality_metric_i(quality_metric_i),
    .clear_i(clear_i),
    .err_flags_o(err_flags_o), .err_ch_o(err_ch_o), .err_irq_o(err_irq_o),
    .frame_count_o(frame_count_o), .pkt_count_o(pkt_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // behavioural model state
  bit              m_prev_stall [NUM_CH];
  logic [DATA_W-1:0] m_prev_data [NUM_CH];
  int              m_stall_run  [NUM_CH];
  int              m_beats      [NUM_CH];
  int              m_frames     [NUM_CH];
  bit              m_open;
  int              m_len;
  int              m_pkts;
  logic [7:0]      m_flags;
  logic [NUM_CH-1:0] m_chm;
  logic            m_irq;

  task automatic model_update();
    logic [7:0]        ev;
    logic [7:0]        base;
    logic [NUM_CH-1:0] chev;
    bit                frame_done [NUM_CH];
    bit                pkt_done;
    if (reset_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_prev_stall[c] = 0; m_stall_run[c] = 0; m_beats[c] = 0; m_frames[c] = 0;
      end
      m_open = 0; m_len = 0; m_pkts = 0; m_flags = '0; m_chm = '0; m_irq = 1'b0;
      return;
    end
    ev = '0; chev = '0; pkt_done = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      logic v, r;
      logic [DATA_W-1:0] d;
      v = ch_valid_i[c]; r = ch_ready_i[c]; d = ch_data_i[c*DATA_W +: DATA_W];
      frame_done[c] = 0;
      if (m_prev_stall[c] && !v) begin ev[0] = 1; chev[c] = 1; end
      if (m_prev_stall[c] && v && d != m_prev_data[c]) begin ev[1] = 1; chev[c] = 1; end
      if (v && !r) begin
        if (m_stall_run[c] < TIMEOUT_CYC) begin
          m_stall_run[c]++;
          if (m_stall_run[c] == TIMEOUT_CYC) begin ev[2] = 1; chev[c] = 1; end
        end
      end else begin
        m_stall_run[c] = 0;
      end
      if (v && r) begin
        m_beats[c]++;
        if (m_beats[c] == FRAME_LEN) begin m_beats[c] = 0; frame_done[c] = 1; end
      end
      m_prev_stall[c] = v && !r;
      m_prev_data[c]  = d;
    end
    if (pkt_valid_i && pkt_ready_i) begin
      if (pkt_start_i && pkt_end_i) ev[3] = 1;
      if (!m_open) begin
        if (!pkt_start_i) ev[5] = 1;
        else if (!pkt_end_i) begin m_open = 1; m_len = 1; end
      end else begin
        if (pkt_start_i) begin ev[4] = 1; m_len = 1; end
        else if (pkt_end_i) begin m_open = 0; pkt_done = 1; end
        else if (m_len + 1 > MAX_PKT_LEN) begin ev[6] = 1; m_open = 0; end
        else m_len++;
      end
    end
    if (quality_valid_i && quality_metric_i > 100) ev[7] = 1;
    base    = clear_i ? 8'h00 : m_flags;
    m_irq   = |(ev & ~base);
    m_flags = base | ev;
    m_chm   = (clear_i ? '0 : m_chm) | chev;
    for (int c = 0; c < NUM_CH; c++) begin
      if (clear_i) m_frames[c] = 0;
      else if (frame_done[c] && m_frames[c] < CNT_MAX) m_frames[c]++;
    end
    if (clear_i) m_pkts = 0;
    else if (pkt_done && m_pkts < CNT_MAX) m_pkts++;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("flags", err_flags_o, m_flags);
    chk("err_ch", err_ch_o, m_chm);
    chk("irq", err_irq_o, m_irq);
    for (int c = 0; c < NUM_CH; c++) chk("frames", frame_count_o[c*CNT_W +: CNT_W], m_frames[c]);
    chk("pkts", pkt_count_o, m_pkts);
  endtask

  task automatic set_idle();
    reset_i = 0; clear_i = 0;
    ch_valid_i = '0; ch_ready_i = '0; ch_data_i = '0;
    pkt_valid_i = 0; pkt_ready_i = 0; pkt_data_i = '0; pkt_start_i = 0; pkt_end_i = 0;
    quality_valid_i = 0; quality_metric_i = '0;
  endtask

  task automatic do_reset(input int n);
    set_idle();
    reset_i = 1;
    repeat (n) step();
    reset_i = 0;
  endtask

  task automatic pkt_beat(input logic s, input logic e);
    pkt_valid_i = 1; pkt_ready_i = 1; pkt_start_i = s; pkt_end_i = e;
    pkt_data_i = PKT_W'($urandom);
    step();
    pkt_valid_i = 0; pkt_start_i = 0; pkt_end_i = 0;
  endtask

  initial begin
    set_idle();
    do_reset(3);
    chk("rst_flags", err_flags_o, 8'h00);
    chk("rst_irq", err_irq_o, 1'b0);
    chk("rst_pkts", pkt_count_o, 0);

    // stability: data changes while stalled
    ch_valid_i[0] = 1; ch_ready_i[0] = 0; ch_data_i[15:0] = 16'h1234;
    step(); step();
    chk("t1_quiet", err_flags_o, 8'h00);
    ch_data_i[15:0] = 16'h1235;
    step();
    chk("t1_bit1", err_flags_o[1], 1'b1);
    chk("t1_ch0", err_ch_o, 2'b01);
    chk("t1_irq", err_irq_o, 1'b1);
    ch_ready_i[0] = 1;
    step();
    chk("t1_irq_once", err_irq_o, 1'b0);
    ch_valid_i[0] = 0; ch_ready_i[0] = 0;
    step();
    clear_i = 1; step(); clear_i = 0;
    chk("t1_clear", err_flags_o, 8'h00);

    // stall timeout on channel 1
    do_reset(2);
    ch_valid_i[1] = 1; ch_ready_i[1] = 0; ch_data_i[31:16] = 16'hBEEF;
    repeat (TIMEOUT_CYC - 1) step();
    chk("t2_pre", err_flags_o[2], 1'b0);
    step();
    chk("t2_bit2", err_flags_o[2], 1'b1);
    chk("t2_irq", err_irq_o, 1'b1);
    chk("t2_ch", err_ch_o, 2'b10);
    repeat (20) begin
      step();
      chk("t2_no_reirq", err_irq_o, 1'b0);
    end
    ch_ready_i[1] = 1; step();
    ch_valid_i[1] = 0; ch_ready_i[1] = 0;
    // reset in the middle of a stall
    ch_valid_i[0] = 1; repeat (5) step();
    do_reset(1);
    chk("t2_rst_flags", err_flags_o, 8'h00);

    // frames
    do_reset(2);
    ch_valid_i[0] = 1; ch_ready_i[0] = 1;
    repeat (32) begin ch_data_i[15:0] = 16'($urandom); step(); end
    ch_valid_i[0] = 0; ch_ready_i[0] = 0;
    step();
    chk("t3_f0", frame_count_o[CNT_W-1:0], 2);
    chk("t3_f1", frame_count_o[2*CNT_W-1:CNT_W], 0);
    chk("t3_noerr", err_flags_o, 8'h00);
    do_reset(2);
    ch_valid_i[0] = 1; ch_ready_i[0] = 1;
    repeat (FRAME_LEN * (CNT_MAX + 2)) step();
    ch_valid_i[0] = 0; ch_ready_i[0] = 0;
    chk("t3_fsat", frame_count_o[CNT_W-1:0], CNT_MAX);

    // packets
    do_reset(2);
    pkt_beat(1, 0); repeat (3) pkt_beat(0, 0); pkt_beat(0, 1);
    chk("t4_pkt1", pkt_count_o, 1);
    chk("t4_noerr", err_flags_o, 8'h00);
    pkt_beat(1, 1);
    chk("t4_se", err_flags_o, 8'h08);
    chk("t4_se_cnt", pkt_count_o, 1);
    do_reset(2);
    pkt_beat(1, 0); pkt_beat(1, 0); pkt_beat(0, 1);
    chk("t4_nest", err_flags_o, 8'h10);
    chk("t4_nest_cnt", pkt_count_o, 1);
    pkt_beat(1, 0);
    repeat (MAX_PKT_LEN) pkt_beat(0, 0);
    chk("t4_len", err_flags_o[6], 1'b1);
    chk("t4_len_noorph", err_flags_o[5], 1'b0);
    pkt_beat(0, 0);
    chk("t4_idle_orphan", err_flags_o[5], 1'b1);
    chk("t4_len_cnt", pkt_count_o, 1);
    do_reset(2);
    repeat (CNT_MAX + 5) begin pkt_beat(1, 0); pkt_beat(0, 1); end
    chk("t4_psat", pkt_count_o, CNT_MAX);

    // quality
    do_reset(2);
    quality_valid_i = 1; quality_metric_i = 8'd100; step();
    chk("t5_100", err_flags_o, 8'h00);
    quality_metric_i = 8'd101; step();
    chk("t5_101", err_flags_o, 8'h80);
    chk("t5_irq", err_irq_o, 1'b1);
    quality_valid_i = 0; step();
    chk("t5_irq_off", err_irq_o, 1'b0);
    quality_valid_i = 1; quality_metric_i = 8'd150; clear_i = 1; step();
    clear_i = 0; quality_valid_i = 0;
    chk("t5_clr_flags", err_flags_o, 8'h80);
    chk("t5_clr_irq", err_irq_o, 1'b1);

    // random traffic
    do_reset(2);
    repeat (4000) begin
      reset_i = ($urandom_range(0, 199) == 0);
      clear_i = ($urandom_range(0, 49) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_prev_stall[c] && $urandom_range(0, 9) != 0) begin
          ch_ready_i[c] = $urandom_range(0, 1);
        end else begin
          ch_valid_i[c] = ($urandom_range(0, 3) != 0);
          ch_ready_i[c] = $urandom_range(0, 1);
          ch_data_i[c*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 3));
        end
      end
      pkt_valid_i = ($urandom_range(0, 9) < 7);
      pkt_ready_i = ($urandom_range(0, 9) < 7);
      pkt_start_i = ($urandom_range(0, 19) < 3);
      pkt_end_i   = ($urandom_range(0, 19) < 3);
      pkt_data_i  = PKT_W'($urandom);
      quality_valid_i  = ($urandom_range(0, 9) == 0);
      quality_metric_i = 8'($urandom_range(0, 120));
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
